// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the RV64 pipeline: serialises instruction fetch and
// MEM-stage load/store accesses over one 64-bit req/ack port, data first with bounded fetch starvation.
module mem_port_arbiter #(
  parameter int unsigned FETCH_STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [63:0] dm_wdata,
  input  logic [7:0]  dm_wmask,
  output logic        dm_rvalid,
  output logic [63:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        stall,
  output logic        err_spurious_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic [3:0] STARVE_MAX = 4'(FETCH_STARVE_MAX);

  state_e      state_q;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        grant_dm_d, grant_if_d;
  logic        spurious_ack_d;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q;
  logic [63:0] mem_wdata_q;
  logic [7:0]  mem_wmask_q;
  logic        if_hi_q;
  logic        if_rvalid_q, dm_rvalid_q;
  logic [31:0] if_rdata_q;
  logic [63:0] dm_rdata_q;
  logic        err_q;
  logic        unused_if_addr_lo;

  // Fetch addresses are word aligned; the low bits carry no information here.
  assign unused_if_addr_lo = ^if_addr[1:0];

  assign spurious_ack_d = mem_ack && ((state_q == IDLE) || (state_q == RESP));

  // Grant decision and starvation counter next state; only evaluated in IDLE.
  always_comb begin
    grant_dm_d   = 1'b0;
    grant_if_d   = 1'b0;
    starve_cnt_d = starve_cnt_q;
    if (state_q == IDLE) begin
      if (dm_req && !(if_req && (starve_cnt_q == STARVE_MAX))) begin
        grant_dm_d = 1'b1;
        if (if_req) begin
          starve_cnt_d = (starve_cnt_q >= STARVE_MAX) ? STARVE_MAX : (starve_cnt_q + 4'd1);
        end else begin
          starve_cnt_d = 4'd0;
        end
      end else if (if_req) begin
        grant_if_d   = 1'b1;
        starve_cnt_d = 4'd0;
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Transaction sequencer with registered memory-port and response outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 64'd0;
      mem_wmask_q  <= 8'h00;
      if_hi_q      <= 1'b0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      if_rdata_q   <= 32'd0;
      dm_rdata_q   <= 64'd0;
      err_q        <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      if (spurious_ack_d) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (grant_dm_d) begin
            state_q     <= BUSY_DM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
            mem_wmask_q <= dm_we ? dm_wmask : 8'h00;
          end else if (grant_if_d) begin
            state_q     <= BUSY_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {if_addr[31:3], 3'b000};
            mem_wdata_q <= 64'd0;
            mem_wmask_q <= 8'h00;
            if_hi_q     <= if_addr[2];
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY_IF: begin
          if (mem_ack) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= if_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
          end
        end
        BUSY_DM: begin
          if (mem_ack) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            dm_rvalid_q <= 1'b1;
            // A store completes without disturbing the last load result.
            if (!mem_we_q) begin
              dm_rdata_q <= mem_rdata;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req          = mem_req_q;
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign mem_wmask        = mem_wmask_q;
  assign if_rvalid        = if_rvalid_q;
  assign if_rdata         = if_rdata_q;
  assign dm_rvalid        = dm_rvalid_q;
  assign dm_rdata         = dm_rdata_q;
  assign err_spurious_ack = err_q;
  assign stall            = (if_req && !if_rvalid_q) || (dm_req && !dm_rvalid_q);

endmodule
